// File: rtl/alarm_time_setter_pkg.sv
// Shared types, limits and 7-segment codes for the alarm time setter.
package alarm_time_setter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  // Segment order abcdefg with g in the LSB, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Tens digit of an hour value, by compare chain rather than division.
  function automatic logic [3:0] hour_tens(input logic [4:0] v);
    if (v >= 5'd20)      return 4'd2;
    else if (v >= 5'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] hour_ones(input logic [4:0] v);
    return 4'(v - ({1'b0, hour_tens(v)} * 5'd10));
  endfunction

  // Tens digit of a minute value, compare chain up to 50.
  function automatic logic [3:0] min_tens(input logic [5:0] v);
    if (v >= 6'd50)      return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] min_ones(input logic [5:0] v);
    return 4'(v - ({2'b00, min_tens(v)} * 6'd10));
  endfunction

endpackage

// File: rtl/alarm_time_setter_seg7_digit.sv
// BCD digit to 7-segment decoder; anything above 9 shows blank.
module seg7_digit
  import alarm_time_setter_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup from digit value to segment pattern.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alarm_time_setter.sv
// Alarm time setter: edit FSM, shadow edit counters, committed alarm
// registers and the six-digit alarm-mode display with field blinking.
module alarm_time_setter
  import alarm_time_setter_pkg::*;
#(
  parameter int RESET_HOURS   = 0,
  parameter int RESET_MINUTES = 0,
  parameter int BLINK_EN      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       real_quarter,
  input  logic       pulsed_set,
  input  logic       pulsed_up,
  input  logic       pulsed_down,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
  output logic [6:0] disp4,
  output logic [6:0] disp5,
  output logic [1:0] state
);

  localparam logic [4:0] RST_H = 5'(RESET_HOURS);
  localparam logic [5:0] RST_M = 6'(RESET_MINUTES);

  state_t     state_q;
  logic [4:0] edit_h_q, edit_h_d;
  logic [5:0] edit_m_q, edit_m_d;
  logic [4:0] alarm_h_q;
  logic [5:0] alarm_m_q;

  logic       step_up, step_down;
  logic [4:0] show_h;
  logic [5:0] show_m;
  logic       blank_h, blank_m;
  logic [6:0] seg_ht, seg_ho, seg_mt, seg_mo;

  // Up and down together cancel each other out.
  assign step_up   = pulsed_up & ~pulsed_down;
  assign step_down = pulsed_down & ~pulsed_up;

  // Stepped edit values with explicit wrap compares; the FSM decides whether to use them.
  always_comb begin
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    if (step_up) begin
      edit_h_d = (edit_h_q >= MAX_HOUR) ? 5'd0 : edit_h_q + 5'd1;
      edit_m_d = (edit_m_q >= MAX_MIN)  ? 6'd0 : edit_m_q + 6'd1;
    end else if (step_down) begin
      edit_h_d = (edit_h_q == 5'd0) ? MAX_HOUR : edit_h_q - 5'd1;
      edit_m_d = (edit_m_q == 6'd0) ? MAX_MIN  : edit_m_q - 6'd1;
    end
  end

  // Edit FSM: set walks IDLE -> hour -> minute -> commit; losing active aborts the edit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      edit_h_q  <= RST_H;
      edit_m_q  <= RST_M;
      alarm_h_q <= RST_H;
      alarm_m_q <= RST_M;
    end else if (!active || state_q == ST_ILLEGAL) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulsed_set) begin
            state_q  <= ST_SET_HOUR;
            edit_h_q <= alarm_h_q;
            edit_m_q <= alarm_m_q;
          end
        end
        ST_SET_HOUR: begin
          if (pulsed_set) state_q  <= ST_SET_MIN;
          else            edit_h_q <= edit_h_d;
        end
        ST_SET_MIN: begin
          if (pulsed_set) begin
            state_q   <= ST_IDLE;
            alarm_h_q <= edit_h_q;
            alarm_m_q <= edit_m_q;
          end else begin
            edit_m_q <= edit_m_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // While editing the display follows the shadow values, otherwise the committed time.
  always_comb begin
    show_h  = alarm_h_q;
    show_m  = alarm_m_q;
    if (state_q == ST_SET_HOUR || state_q == ST_SET_MIN) begin
      show_h = edit_h_q;
      show_m = edit_m_q;
    end
    blank_h = (BLINK_EN != 0) && !real_quarter && (state_q == ST_SET_HOUR);
    blank_m = (BLINK_EN != 0) && !real_quarter && (state_q == ST_SET_MIN);
  end

  seg7_digit u_hour_tens (.bcd_i(hour_tens(show_h)), .seg_o(seg_ht));
  seg7_digit u_hour_ones (.bcd_i(hour_ones(show_h)), .seg_o(seg_ho));
  seg7_digit u_min_tens  (.bcd_i(min_tens(show_m)),  .seg_o(seg_mt));
  seg7_digit u_min_ones  (.bcd_i(min_ones(show_m)),  .seg_o(seg_mo));

  assign disp0 = blank_h ? SEG_BLANK : seg_ht;
  assign disp1 = blank_h ? SEG_BLANK : seg_ho;
  assign disp2 = blank_m ? SEG_BLANK : seg_mt;
  assign disp3 = blank_m ? SEG_BLANK : seg_mo;
  assign disp4 = SEG_0;
  assign disp5 = SEG_0;

  assign alarm_hours   = alarm_h_q;
  assign alarm_minutes = alarm_m_q;
  assign state         = state_q;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Self-checking bench for alarm_time_setter: directed scenarios with literal
// expectations, then randomized pulses checked every cycle against a model.
module tb_alarm_time_setter;

  localparam int RH    = 0;
  localparam int RM    = 0;
  localparam int BLINK = 1;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SB = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active = 1'b0;
  logic       realQuarter = 1'b1;
  logic       pulsedSet = 1'b0;
  logic       pulsedUp = 1'b0;
  logic       pulsedDown = 1'b0;
  logic [4:0] alarmHours;
  logic [5:0] alarmMinutes;
  logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  // Reference model: mode 0 idle, 1 editing hour, 2 editing minute.
  int mMode = 0;
  int mEh = RH, mEm = RM, mAh = RH, mAm = RM;

  alarm_time_setter #(
    .RESET_HOURS(RH), .RESET_MINUTES(RM), .BLINK_EN(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .active(active), .real_quarter(realQuarter),
    .pulsed_set(pulsedSet), .pulsed_up(pulsedUp), .pulsed_down(pulsedDown),
    .alarm_hours(alarmHours), .alarm_minutes(alarmMinutes),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
    .disp4(disp4), .disp5(disp5), .state(state)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on each clock edge from the inputs the DUT also samples.
  always @(posedge clk) begin
    if (reset) begin
      mMode = 0; mAh = RH; mAm = RM; mEh = RH; mEm = RM;
    end else if (!active) begin
      mMode = 0;
    end else begin
      case (mMode)
        0: if (pulsedSet) begin mMode = 1; mEh = mAh; mEm = mAm; end
        1: begin
          if (pulsedSet) mMode = 2;
          else if (pulsedUp && !pulsedDown) mEh = (mEh + 1) % 24;
          else if (pulsedDown && !pulsedUp) mEh = (mEh + 23) % 24;
        end
        default: begin
          if (pulsedSet) begin mMode = 0; mAh = mEh; mAm = mEm; end
          else if (pulsedUp && !pulsedDown) mEm = (mEm + 1) % 60;
          else if (pulsedDown && !pulsedUp) mEm = (mEm + 59) % 60;
        end
      endcase
    end
  end

  // Compare every DUT output against the model midway through each cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      int h, m;
      bit bh, bm;
      h  = (mMode == 0) ? mAh : mEh;
      m  = (mMode == 0) ? mAm : mEm;
      bh = (BLINK != 0) && !realQuarter && (mMode == 1);
      bm = (BLINK != 0) && !realQuarter && (mMode == 2);
      checkOutput("state", 32'(state), 32'(mMode));
      checkOutput("alarm_hours", 32'(alarmHours), 32'(mAh));
      checkOutput("alarm_minutes", 32'(alarmMinutes), 32'(mAm));
      checkOutput("disp0", 32'(disp0), 32'(bh ? SB : segOf(h / 10)));
      checkOutput("disp1", 32'(disp1), 32'(bh ? SB : segOf(h % 10)));
      checkOutput("disp2", 32'(disp2), 32'(bm ? SB : segOf(m / 10)));
      checkOutput("disp3", 32'(disp3), 32'(bm ? SB : segOf(m % 10)));
      checkOutput("disp4", 32'(disp4), 32'(S0));
      checkOutput("disp5", 32'(disp5), 32'(S0));
    end
  end

  // Drive one cycle of inputs, let the edge sample them, then drop the pulses.
  task automatic applyStimulus(input logic s, input logic u, input logic d,
                               input logic a, input logic q, input logic r);
    pulsedSet = s; pulsedUp = u; pulsedDown = d;
    active = a; realQuarter = q; reset = r;
    @(posedge clk);
    #1;
    pulsedSet = 1'b0; pulsedUp = 1'b0; pulsedDown = 1'b0; reset = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic u, input logic d, input int n);
    for (int i = 0; i < n; i++) applyStimulus(s, u, d, 1'b1, 1'b1, 1'b0);
  endtask

  // Directed scenarios with literal expectations, followed by random traffic.
  initial begin
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkEn = 1'b1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_hours", 32'(alarmHours), 32'd0);
    checkOutput("rst_minutes", 32'(alarmMinutes), 32'd0);
    checkOutput("rst_disp0", 32'(disp0), 32'(S0));

    pulse(1'b1, 1'b0, 1'b0, 1);
    checkOutput("seq_state1", 32'(state), 32'd1);
    pulse(1'b0, 1'b1, 1'b0, 3);
    pulse(1'b1, 1'b0, 1'b0, 1);
    checkOutput("seq_state2", 32'(state), 32'd2);
    checkOutput("seq_hold_hours", 32'(alarmHours), 32'd0);
    pulse(1'b0, 1'b0, 1'b1, 1);
    pulse(1'b1, 1'b0, 1'b0, 1);
    checkOutput("seq_state0", 32'(state), 32'd0);
    checkOutput("seq_hours", 32'(alarmHours), 32'd3);
    checkOutput("seq_minutes", 32'(alarmMinutes), 32'd59);
    checkOutput("model_hours", 32'(mAh), 32'd3);
    checkOutput("seq_disp0", 32'(disp0), 32'(S0));
    checkOutput("seq_disp1", 32'(disp1), 32'(S3));
    checkOutput("seq_disp2", 32'(disp2), 32'(S5));
    checkOutput("seq_disp3", 32'(disp3), 32'(S9));

    // Hour wrap both directions.
    pulse(1'b1, 1'b0, 1'b0, 1);
    pulse(1'b0, 1'b1, 1'b0, 20);
    checkOutput("h23_disp0", 32'(disp0), 32'(S2));
    checkOutput("h23_disp1", 32'(disp1), 32'(S3));
    pulse(1'b0, 1'b1, 1'b0, 1);
    checkOutput("hwrap_up", 32'(disp1), 32'(S0));
    pulse(1'b0, 1'b0, 1'b1, 1);
    checkOutput("hwrap_down", 32'(disp0), 32'(S2));
    checkOutput("hwrap_commit", 32'(alarmHours), 32'd3);

    // Minute wrap both directions, then abort at minute 10.
    pulse(1'b1, 1'b0, 1'b0, 1);
    pulse(1'b0, 1'b1, 1'b0, 1);
    checkOutput("mwrap_up", 32'(disp2), 32'(S0));
    pulse(1'b0, 1'b0, 1'b1, 1);
    checkOutput("mwrap_down", 32'(disp3), 32'(S9));
    pulse(1'b0, 1'b1, 1'b0, 11);
    checkOutput("m10_disp2", 32'(disp2), 32'(S1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_minutes", 32'(alarmMinutes), 32'd59);
    pulse(1'b1, 1'b0, 1'b0, 1);
    checkOutput("reenter_disp1", 32'(disp1), 32'(S3));
    checkOutput("reenter_disp3", 32'(disp3), 32'(S9));

    // Blinking of the hour pair.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("blink_disp0", 32'(disp0), 32'(SB));
    checkOutput("blink_disp2", 32'(disp2), 32'(S5));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("noblink_disp0", 32'(disp0), 32'(S0));

    // set beats up; up with down is a no-op.
    pulse(1'b1, 1'b1, 1'b0, 1);
    checkOutput("setup_state", 32'(state), 32'd2);
    checkOutput("setup_disp1", 32'(disp1), 32'(S3));
    pulse(1'b0, 1'b1, 1'b1, 1);
    checkOutput("updown_disp3", 32'(disp3), 32'(S9));

    // Reset mid-edit restores reset values.
    pulse(1'b0, 1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rstedit_state", 32'(state), 32'd0);
    checkOutput("rstedit_hours", 32'(alarmHours), 32'd0);
    checkOutput("rstedit_disp3", 32'(disp3), 32'(S0));

    // Random traffic: mostly active, sparse pulses, rare resets.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 30) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 400) == 0);
    end

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
